// File: rtl/jetson_cmd_dispatch_if.sv
// Link FIFO and core register-bus signals seen by the command dispatcher.
// The master side is the dispatcher; the slave side is the link and register bus.
interface jetson_cmd_dispatch_if;
    logic        rd_en;
    logic        rd_rdy;
    logic [31:0] rd_dout;
    logic        wr_en;
    logic [31:0] wr_din;
    logic        wr_full;
    logic        bus_wr;
    logic        bus_rd;
    logic [3:0]  bus_addr;
    logic [23:0] bus_wdata;
    logic [23:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output rd_en, wr_en, wr_din, bus_wr, bus_rd, bus_addr, bus_wdata,
        input  rd_rdy, rd_dout, wr_full, bus_rdata, bus_ack
    );

    modport slave (
        input  rd_en, wr_en, wr_din, bus_wr, bus_rd, bus_addr, bus_wdata,
        output rd_rdy, rd_dout, wr_full, bus_rdata, bus_ack
    );
endinterface

// File: rtl/jetson_cmd_dispatch.sv
// Pops Jetson command words, runs one register-bus transaction each and pushes
// replies; also pushes rate-limited shadow-status words when status_in changes.
module jetson_cmd_dispatch #(
    parameter int TIMEOUT        = 255,
    parameter int STATUS_HOLDOFF = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    jetson_cmd_dispatch_if.master io,
    input  logic [24:0]           status_in,
    output logic                  busy
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_BUS    = 3'd3;
    localparam logic [2:0] S_REPLY  = 3'd4;
    localparam logic [2:0] S_STATUS = 3'd5;

    logic [2:0]  state;
    logic [31:0] cmd_q;
    logic [31:0] reply_q;
    logic [31:0] wr_din_q;
    logic [24:0] last_status;
    logic [15:0] to_cnt;
    logic [19:0] ho_cnt;

    logic [3:0]  opc;
    logic [3:0]  addr;
    logic        ho_done;
    logic        status_due;
    logic        push;
    logic [31:0] push_word;

    assign opc        = cmd_q[31:28];
    assign addr       = cmd_q[27:24];
    assign ho_done    = (ho_cnt == 20'(STATUS_HOLDOFF));
    assign status_due = (status_in != last_status) && ho_done;

    // rd_en/wr_en are decoded from state so a pop or push happens in the very
    // cycle the FSM decides on it; both are gated by rst to keep outputs quiet.
    assign push      = ((state == S_REPLY) || (state == S_STATUS)) && !io.wr_full && !rst;
    assign push_word = (state == S_STATUS) ? {7'h0, status_in} : reply_q;

    assign io.rd_en  = (state == S_IDLE) && !status_due && !rst;
    assign io.wr_en  = push;
    assign io.wr_din = push ? push_word : wr_din_q;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cmd_q        <= '0;
            reply_q      <= '0;
            wr_din_q     <= '0;
            last_status  <= '0;
            to_cnt       <= '0;
            ho_cnt       <= 20'(STATUS_HOLDOFF);
            io.bus_wr    <= 1'b0;
            io.bus_rd    <= 1'b0;
            io.bus_addr  <= '0;
            io.bus_wdata <= '0;
        end else begin
            if (!ho_done) ho_cnt <= ho_cnt + 20'd1;
            if (push) wr_din_q <= push_word;

            case (state)
                S_IDLE: state <= status_due ? S_STATUS : S_FETCH;

                S_FETCH: begin
                    if (io.rd_rdy) begin
                        cmd_q <= io.rd_dout;
                        state <= S_DECODE;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_DECODE: begin
                    to_cnt <= '0;
                    case (opc)
                        4'h1, 4'h2: begin
                            io.bus_wr    <= (opc == 4'h1);
                            io.bus_rd    <= (opc == 4'h2);
                            io.bus_addr  <= addr;
                            io.bus_wdata <= cmd_q[23:0];
                            state        <= S_BUS;
                        end
                        4'h3: begin
                            reply_q <= {4'h3, cmd_q[27:0]};
                            state   <= S_REPLY;
                        end
                        default: begin
                            reply_q <= {4'hF, 20'h0, 4'h0, opc};
                            state   <= S_REPLY;
                        end
                    endcase
                end

                // An ack in the same cycle the counter hits TIMEOUT still wins.
                S_BUS: begin
                    if (io.bus_ack) begin
                        io.bus_wr <= 1'b0;
                        io.bus_rd <= 1'b0;
                        if (opc == 4'h2) begin
                            reply_q <= {4'h2, addr, io.bus_rdata};
                            state   <= S_REPLY;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (to_cnt == 16'(TIMEOUT)) begin
                        io.bus_wr <= 1'b0;
                        io.bus_rd <= 1'b0;
                        reply_q   <= {4'hE, addr, 23'h0, (opc == 4'h1)};
                        state     <= S_REPLY;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end

                S_REPLY: if (push) state <= S_IDLE;

                S_STATUS: begin
                    if (push) begin
                        last_status <= status_in;
                        ho_cnt      <= '0;
                        state       <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jetson_cmd_dispatch.sv
// Directed bench for jetson_cmd_dispatch: FIFO and register-bus models plus a
// negedge monitor; expected words and latencies are hand-computed constants.
module tb_jetson_cmd_dispatch;
    localparam int TO = 8;
    localparam int HO = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [24:0] status_in = '0;
    logic        busy;

    jetson_cmd_dispatch_if bif();

    jetson_cmd_dispatch #(.TIMEOUT(TO), .STATUS_HOLDOFF(HO)) dut (
        .clk(clk), .rst(rst), .io(bif), .status_in(status_in), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // FIFO model: a pop requested in one cycle presents its word the next.
    logic [31:0] fifo_mem [64];
    int          pop_t    [64];
    int          fifo_wp = 0;
    int          fifo_rp = 0;
    always @(posedge clk) begin
        if (rst) bif.rd_rdy <= 1'b0;
        else if (bif.rd_en && fifo_rp < fifo_wp) begin
            bif.rd_rdy     <= 1'b1;
            bif.rd_dout    <= fifo_mem[fifo_rp];
            pop_t[fifo_rp] <= cyc;
            fifo_rp        <= fifo_rp + 1;
        end else bif.rd_rdy <= 1'b0;
    end

    // Register-bus model: ack arrives in request cycle ack_dly+2; -1 never acks.
    int          ack_dly = -1;
    int          bcnt = 0;
    logic        m_ack = 1'b0;
    logic        ack_force = 1'b0;
    logic [23:0] rdata_v = '0;
    always @(posedge clk) begin
        if ((bif.bus_wr || bif.bus_rd) && !m_ack) begin
            if (ack_dly >= 0 && bcnt == ack_dly) m_ack <= 1'b1;
            else bcnt <= bcnt + 1;
        end else begin
            m_ack <= 1'b0;
            bcnt  <= 0;
        end
    end
    assign bif.bus_ack   = m_ack | ack_force;
    assign bif.bus_rdata = rdata_v;

    logic [31:0] wr_d [128];
    int          wr_t [128];
    int          n_wr = 0, n_rd = 0, n_both = 0, n_wfull = 0;
    int          n_req = 0, n_wreq = 0, n_bad = 0;
    logic [27:0] exp_req = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (bif.wr_en && n_wr < 128) begin
                wr_d[n_wr] <= bif.wr_din;
                wr_t[n_wr] <= cyc;
                n_wr       <= n_wr + 1;
            end
            if (bif.rd_en) n_rd <= n_rd + 1;
            if (bif.rd_en && bif.wr_en) n_both <= n_both + 1;
            if (bif.wr_en && bif.wr_full) n_wfull <= n_wfull + 1;
            if (bif.bus_wr || bif.bus_rd) n_req <= n_req + 1;
            if (bif.bus_wr) n_wreq <= n_wreq + 1;
            if ((bif.bus_wr || bif.bus_rd) && {bif.bus_addr, bif.bus_wdata} != exp_req)
                n_bad <= n_bad + 1;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] w);
        fifo_mem[fifo_wp] = w;
        fifo_wp++;
    endtask

    task automatic wait_wr(input int n, input int budget);
        int k = 0;
        while (n_wr < n && k < budget) begin
            tick();
            k++;
        end
    endtask

    int b, rq, bw, bad, i0, ts, td;

    initial begin
        bif.wr_full = 1'b0;
        tick(3);
        chk("rst_rd_en", 32'(bif.rd_en), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        chk("rst_wr_en", 32'(bif.wr_en), 0);
        chk("rst_wr_din", bif.wr_din, 0);
        chk("rst_bus", 32'({bif.bus_wr, bif.bus_rd}), 0);

        b = n_rd;
        tick(10);
        chk("empty_poll", n_rd - b, 5);

        // PING latency and no bus activity
        b = n_wr; rq = n_req; i0 = fifo_wp;
        push(32'h3ABCDEF1);
        wait_wr(b + 1, 40);
        chk("ping_data", wr_d[b], 32'h3ABCDEF1);
        chk("ping_lat", wr_t[b] - pop_t[i0], 3);
        chk("ping_nobus", n_req - rq, 0);

        // back-to-back PINGs: 4 cycles per command
        b = n_wr; i0 = fifo_wp;
        push(32'h30000001);
        push(32'h3FFFFFFF);
        wait_wr(b + 2, 60);
        chk("ping2_d0", wr_d[b], 32'h30000001);
        chk("ping2_d1", wr_d[b+1], 32'h3FFFFFFF);
        chk("ping_rate", pop_t[i0+1] - pop_t[i0], 4);

        // WRITE with ack in the third request cycle
        exp_req = {4'h5, 24'h123456}; ack_dly = 1;
        b = n_wr; rq = n_req; bw = n_wreq; bad = n_bad;
        push(32'h15123456);
        tick(30);
        chk("wr_req_cyc", n_req - rq, 3);
        chk("wr_bus_wr", n_wreq - bw, 3);
        chk("wr_stable", n_bad - bad, 0);
        chk("wr_noreply", n_wr - b, 0);

        // READ with the reply held off by wr_full
        bif.wr_full = 1'b1;
        exp_req = {4'h7, 24'h0}; rdata_v = 24'hCAFE01; ack_dly = 0;
        b = n_wr; rq = n_req;
        push(32'h27000000);
        tick(15);
        chk("rd_req_cyc", n_req - rq, 2);
        chk("rd_held", n_wr - b, 0);
        bif.wr_full = 1'b0;
        td = cyc;
        wait_wr(b + 1, 10);
        chk("rd_data", wr_d[b], 32'h27CAFE01);
        chk("rd_when_free", wr_t[b], td);
        tick(5);
        chk("rd_single", n_wr - b, 1);

        // READ timeout, then a stray ack
        exp_req = {4'h3, 24'h0}; ack_dly = -1;
        b = n_wr; rq = n_req;
        push(32'h23000000);
        wait_wr(b + 1, 60);
        chk("to_rd_data", wr_d[b], 32'hE3000000);
        chk("to_rd_cyc", n_req - rq, TO + 1);
        ack_force = 1'b1;
        tick();
        ack_force = 1'b0;
        tick(10);
        chk("late_ack_wr", n_wr - b, 1);
        chk("late_ack_req", n_req - rq, TO + 1);

        // WRITE timeout flags was_write
        exp_req = {4'hA, 24'h000001};
        b = n_wr;
        push(32'h1A000001);
        wait_wr(b + 1, 60);
        chk("to_wr_data", wr_d[b], 32'hEA000001);

        // ack exactly when the counter reaches TIMEOUT is a success
        exp_req = {4'h4, 24'h0}; ack_dly = TO - 1; rdata_v = 24'h000ABC;
        b = n_wr; rq = n_req;
        push(32'h24000000);
        wait_wr(b + 1, 60);
        chk("edge_ack_data", wr_d[b], 32'h24000ABC);
        chk("edge_ack_cyc", n_req - rq, TO + 1);

        // illegal opcodes
        b = n_wr;
        push(32'h0ABCDEF0);
        push(32'h91234567);
        wait_wr(b + 2, 60);
        chk("bad_op0", wr_d[b], 32'hF0000000);
        chk("bad_op9", wr_d[b+1], 32'hF0000009);

        // reset during a bus transaction
        exp_req = {4'h6, 24'h0}; ack_dly = -1;
        push(32'h26000000);
        for (int k = 0; k < 20 && !bif.bus_rd; k++) tick();
        chk("mid_rst_req", 32'(bif.bus_rd), 1);
        tick(2);
        rst = 1'b1;
        tick();
        chk("mid_rst_drop", 32'(bif.bus_rd), 0);
        rst = 1'b0;
        b = n_wr;
        tick(20);
        chk("mid_rst_noreply", n_wr - b, 0);

        // status pushes with hold-off, PINGs served in between
        b = n_wr;
        status_in = 25'h1000005;
        ts = cyc;
        tick(5);
        status_in = 25'h0000003;
        push(32'h30000011);
        push(32'h30000022);
        push(32'h30000033);
        wait_wr(b + 5, 80);
        chk("st_first", wr_d[b], 32'h01000005);
        chk("st_first_lat", 32'((wr_t[b] - ts) <= 2), 1);
        chk("st_ping_a", wr_d[b+1], 32'h30000011);
        chk("st_ping_b", wr_d[b+2], 32'h30000022);
        chk("st_ping_c", wr_d[b+3], 32'h30000033);
        chk("st_second", wr_d[b+4], 32'h00000003);
        chk("st_holdoff", 32'((wr_t[b+4] - wr_t[b]) >= HO), 1);

        chk("rd_wr_overlap", n_both, 0);
        chk("push_when_full", n_wfull, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
